// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - shared types, JK function codes and next-state helper for the JK counter
package jk_ctrl_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_t;

   // JK function codes, written as {J,K}
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] RST  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] TOG  = 2'b11;

   // Characteristic equation of a JK flip-flop
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic nxt;
      case ({j, k})
         HOLD:    nxt = q;
         RST:     nxt = 1'b0;
         SET:     nxt = 1'b1;
         TOG:     nxt = ~q;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-high clear
module jk_cell
   import jk_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   // Apply the JK function on each rising edge; reset forces the cell to 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         q <= jk_next(q, j, k);
      end
   end

endmodule

// File: rtl/jk_counter_ctrl.sv
// rtl/jk_counter_ctrl.sv - load/count sequencing controller driving a bank of JK cells
module jk_counter_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] count_len,
   input  logic             pause,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] remaining_nxt;
   logic [WIDTH-1:0] load_r;
   logic [WIDTH-1:0] load_nxt;
   logic             dir_r;
   logic             dir_nxt;
   logic [WIDTH-1:0] mask;

   // The JK bank itself; the controller only ever steers J/K
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j_out[g]),
         .k     (k_out[g]),
         .q     (q[g])
      );
   end

   // Toggle mask: bit i flips when every lower bit is at the carry (up) or borrow (down) value
   always_comb begin : toggle_mask
      logic chain;
      chain   = 1'b1;
      mask    = '0;
      mask[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         chain   = chain & (q[i-1] == dir_r);
         mask[i] = chain;
      end
   end

   // Next-state, captured-operand updates and J/K drive
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      load_nxt      = load_r;
      dir_nxt       = dir_r;
      j_out         = '0;
      k_out         = '0;
      case (state)
         IDLE: begin
            if (start) begin
               dir_nxt       = dir;
               load_nxt      = load_val;
               remaining_nxt = count_len;
               state_nxt     = LOAD;
            end
         end
         LOAD: begin
            // Per-bit forced set or clear lands load_r in the bank in one edge
            j_out     = load_r;
            k_out     = ~load_r;
            state_nxt = (remaining != '0) ? RUN : DONE;
         end
         RUN: begin
            if (!pause) begin
               j_out         = mask;
               k_out         = mask;
               remaining_nxt = remaining - ONE;
               if (remaining == ONE) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Status outputs decoded from state and the live bank value
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
      tc   = (state == RUN) && (dir_r ? (&q) : (~|q));
   end

   // Controller registers; an asynchronous reset aborts any sequence without a done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         load_r    <= '0;
         dir_r     <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         load_r    <= load_nxt;
         dir_r     <= dir_nxt;
      end
   end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb/tb_jk_counter_ctrl.sv - self-checking bench for jk_counter_ctrl against an arithmetic reference model
module tb_jk_counter_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       dir;
   logic [3:0] load_val;
   logic [3:0] count_len;
   logic       pause;
   logic [3:0] q;
   logic [3:0] j_out;
   logic [3:0] k_out;
   logic       busy;
   logic       done;
   logic       tc;

   int total = 0;
   int bad   = 0;

   // reference model: phase 0 idle, 1 load, 2 counting, 3 finished
   int ph, mq, mrem, mload, mlen;
   bit mdir;

   int busy_cyc, done_cyc, pause_cyc;

   jk_counter_ctrl #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dir       (dir),
      .load_val  (load_val),
      .count_len (count_len),
      .pause     (pause),
      .q         (q),
      .j_out     (j_out),
      .k_out     (k_out),
      .busy      (busy),
      .done      (done),
      .tc        (tc)
   );

   always #5 clk = ~clk;

   function automatic int step_val(input int v, input bit up);
      return up ? (v + 1) % 16 : (v + 15) % 16;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph = 0; mq = 0; mrem = 0; mdir = 0; mload = 0; mlen = 0;
   endtask

   task automatic model_edge();
      case (ph)
         0: if (start) begin
               mdir = dir; mload = int'(load_val); mrem = int'(count_len);
               mlen = int'(count_len); ph = 1;
            end
         1: begin mq = mload; ph = (mrem != 0) ? 2 : 3; end
         2: if (!pause) begin
               mq = step_val(mq, mdir); mrem--;
               if (mrem == 0) ph = 3;
            end
         default: ph = 0;
      endcase
   endtask

   task automatic check_outputs();
      int ej, ek, etc;
      ej = 0; ek = 0;
      if (ph == 1) begin
         ej = mload; ek = (~mload) & 15;
      end else if (ph == 2 && !pause) begin
         ej = mq ^ step_val(mq, mdir); ek = ej;
      end
      etc = (ph == 2) && (mdir ? (mq == 15) : (mq == 0));
      chk("q",     32'(q),     32'(mq));
      chk("j_out", 32'(j_out), 32'(ej));
      chk("k_out", 32'(k_out), 32'(ek));
      chk("busy",  32'(busy),  32'(ph != 0));
      chk("done",  32'(done),  32'(ph == 3));
      chk("tc",    32'(tc),    32'(etc));
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_cyc++;
      if (ph == 2 && pause) pause_cyc++;
   endtask

   task automatic tick();
      #1;
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input bit d, input int lv, input int cl, input int p_after,
                          input int p_len, input bit noise, input bit rnd_pause);
      int cycles, expq;
      busy_cyc = 0; done_cyc = 0; pause_cyc = 0; cycles = 0;
      dir = d; load_val = 4'(lv); count_len = 4'(cl); pause = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      while (ph != 0 && cycles < 100) begin
         if (rnd_pause) pause = ($urandom_range(0, 2) == 0);
         else pause = (ph == 2) && ((mlen - mrem) == p_after) && (pause_cyc < p_len);
         if (noise) begin
            start = 1'($urandom_range(0, 1)); dir = 1'($urandom);
            load_val = 4'($urandom); count_len = 4'($urandom);
         end
         tick();
         cycles++;
      end
      pause = 1'b0; start = 1'b0;
      chk("no_timeout", 32'(cycles < 100), 32'd1);
      expq = d ? (lv + cl) % 16 : (lv + 16 - cl) % 16;
      chk("final_q", 32'(q), 32'(expq));
      chk("busy_len", 32'(busy_cyc), 32'(cl + 2 + pause_cyc));
      chk("done_pulses", 32'(done_cyc), 32'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; dir = 1'b0; load_val = '0; count_len = '0; pause = 1'b0;
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();

      // up count 3..8, busy 7 cycles
      run_seq(1'b1, 3, 5, 0, 0, 1'b0, 1'b0);
      chk("up_busy7", 32'(busy_cyc), 32'd7);
      // down through zero
      run_seq(1'b0, 1, 3, 0, 0, 1'b0, 1'b0);
      // up through all-ones
      run_seq(1'b1, 14, 3, 0, 0, 1'b0, 1'b0);
      // pause for two cycles after the first step
      run_seq(1'b1, 0, 4, 1, 2, 1'b0, 1'b0);
      chk("pause_cycles", 32'(pause_cyc), 32'd2);
      chk("pause_busy8", 32'(busy_cyc), 32'd8);
      // zero-length sequence
      run_seq(1'b1, 9, 0, 0, 0, 1'b0, 1'b0);
      chk("zero_busy2", 32'(busy_cyc), 32'd2);
      tick();

      // start ignored in RUN, then reset mid-RUN aborts without done
      busy_cyc = 0; done_cyc = 0; pause_cyc = 0;
      dir = 1'b1; load_val = 4'd2; count_len = 4'd9; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1; dir = 1'b0; load_val = 4'd7; count_len = 4'd1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      chk("abort_q", 32'(q), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();
      tick();
      chk("abort_no_done", 32'(done_cyc), 32'd0);

      run_seq(1'b0, 5, 6, 0, 0, 1'b0, 1'b0);

      // randomized sequences with input noise and random pauses
      for (int n = 0; n < 20; n++) begin
         run_seq(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 0, 0, 1'b1, 1'b1);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_counter_ctrl.md
# jk_counter_ctrl

Sequencing controller for a synchronous counter built from JK flip-flops. Holds a WIDTH-bit bank of JK cells and drives their J/K inputs to load a start value, then count up or down for a programmed number of steps. A start/busy/done handshake lets upstream logic run bounded count sequences. It replaces the fixed "all J=K=1" wiring with per-bit toggle control, so the bank behaves as a true binary counter.

## Interface
- WIDTH, 4, counter width in bits; J/K bank size (≥2)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  begin a sequence; sampled only in IDLE
- dir  in  1  1 = count up, 0 = count down; captured with start
- load_val  in  WIDTH  initial counter value; captured with start
- count_len  in  WIDTH  number of count steps after load (0 allowed); captured with start
- pause  in  1  hold counter and step count while in RUN
- q  out  WIDTH  current JK bank state
- j_out  out  WIDTH  J inputs applied to the bank this cycle
- k_out  out  WIDTH  K inputs applied to the bank this cycle
- busy  out  1  high in LOAD, RUN and DONE
- done  out  1  one-cycle pulse in DONE
- tc  out  1  terminal count: RUN and (dir_r ? q==all-ones : q==0)

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: j_out=k_out=0 (hold). start=1 → capture dir_r, load_r, remaining←count_len; go to LOAD.
- LOAD (1 cycle): j_out=load_r, k_out=~load_r (forced set/clear per bit). Next RUN if remaining≠0, else DONE.
- RUN, pause=0: toggle mask m[0]=1; m[i]=&q[i-1:0] (up) or &~q[i-1:0] (down); j_out=k_out=m. remaining decrements. If remaining==1 → DONE, else stay in RUN.
- RUN, pause=1: j_out=k_out=0; q and remaining held; state held.
- DONE (1 cycle): j_out=k_out=0, done=1; next IDLE.
- Wrap-around is modular: up from all-ones → 0; down from 0 → all-ones. No saturation or error.
- start outside IDLE is ignored. dir, load_val and count_len changes outside IDLE have no effect.
- j_out, k_out, tc and busy are combinational from state, q and captured registers. done is decoded from state.
- Reset (any time, including mid-RUN): state=IDLE, q=0, remaining=0, dir_r=0, load_r=0. Outputs: busy=0, done=0, tc=0, j_out=k_out=0. No done pulse is emitted for an aborted sequence.

## Timing
- start sampled at edge E0 → LOAD during cycle after E0. q=load_val after E1.
- With no pause: q advances once per edge E2..E(1+count_len). DONE occupies the cycle after the last step; IDLE follows.
- busy rises the cycle after E0 and falls the cycle after DONE. Total busy = count_len + 2 cycles + pause cycles.
- count_len=0: LOAD → DONE. q=load_val; busy lasts 2 cycles.
- A new start may be sampled in the first IDLE cycle after DONE.

## Structure
- Shared package jk_ctrl_pkg:
  - state enum (IDLE, LOAD, RUN, DONE)
  - JK function constants: HOLD=2'b00, RST=2'b01, SET=2'b10, TOG=2'b11
- Sub-module jk_cell: a single JK flip-flop with async active-high reset to 0, instantiated WIDTH times by a generate loop. Its q feeds the controller's toggle-mask logic.
- Controller FSM, remaining counter and mask logic live in jk_counter_ctrl.

## Test plan
All scenarios use WIDTH=4.
- Up count: start, dir=1, load_val=3, count_len=5 → q sequence 3,4,5,6,7,8; done one cycle after q=8; busy high 7 cycles.
- Down with wrap: dir=0, load_val=1, count_len=3 → q 1,0,15,14; tc=1 while q=0; j_out=k_out=4'b1111 in the 0→15 step.
- Up wrap: dir=1, load_val=14, count_len=3 → q 14,15,0,1; tc=1 at q=15; mask 4'b1111 at q=15.
- Pause: dir=1, load_val=0, count_len=4; pause=1 for 2 cycles after first step → q holds at 1 with j_out=k_out=0; done delayed 2 cycles; final q=4.
- Zero length: load_val=9, count_len=0 → q=9, LOAD→DONE, done pulses; busy 2 cycles.
- Abort and ignore: start asserted again during RUN → no effect. Reset asserted mid-RUN → q=0, busy=0 immediately, no done pulse. Next start works normally.
